// File: rtl/mlp_pkg.sv
// Shared definitions for the streaming MLP neuron.
//   - act_mode encodings (ACT_NONE / ACT_RELU / ACT_LEAKY; code 3 behaves as none)
//   - LEAKY_SHIFT: arithmetic right shift applied to negative values in leaky mode
//   - state_t: neuron FSM states
//   - sat_add(): signed add with clamp to a given width, returns {clip, sum}
package mlp_pkg;

  localparam logic [1:0] ACT_NONE  = 2'd0;
  localparam logic [1:0] ACT_RELU  = 2'd1;
  localparam logic [1:0] ACT_LEAKY = 2'd2;

  localparam int LEAKY_SHIFT = 3;

  // Wide enough for any supported accumulator width; operands are
  // sign-extended into it so the raw sum can never wrap.
  localparam int SAT_CALC_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_EMIT  = 2'd2
  } state_t;

  typedef struct packed {
    logic                          clip;
    logic signed [SAT_CALC_W-1:0]  sum;
  } sat_res_t;

  // Adds a and b, then clamps the result to a signed range of 'width' bits.
  // 'width' must be a constant below SAT_CALC_W so the clamp logic folds away.
  function automatic sat_res_t sat_add(input logic signed [SAT_CALC_W-1:0] a,
                                       input logic signed [SAT_CALC_W-1:0] b,
                                       input int                           width);
    logic signed [SAT_CALC_W-1:0] raw;
    logic signed [SAT_CALC_W-1:0] lim_hi;
    logic signed [SAT_CALC_W-1:0] lim_lo;
    sat_res_t                     res;
    raw    = a + b;
    lim_hi = (SAT_CALC_W'(64'sd1) <<< (width - 1)) - SAT_CALC_W'(64'sd1);
    lim_lo = -lim_hi - SAT_CALC_W'(64'sd1);
    if (raw > lim_hi) begin
      res.clip = 1'b1;
      res.sum  = lim_hi;
    end else if (raw < lim_lo) begin
      res.clip = 1'b1;
      res.sum  = lim_lo;
    end else begin
      res.clip = 1'b0;
      res.sum  = raw;
    end
    return res;
  endfunction

endpackage

// File: rtl/mlp_act_unit.sv
// Combinational activation and output narrowing for one neuron.
//   i_acc   [ACC_W] signed accumulator value
//   i_mode  [2]     activation select (none / ReLU / leaky; 3 acts as none)
//   o_data  [OUT_W] activated value clamped to the signed OUT_W range
module mlp_act_unit
  import mlp_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int OUT_W = 8
) (
  input  logic signed [ACC_W-1:0] i_acc,
  input  logic        [1:0]       i_mode,
  output logic signed [OUT_W-1:0] o_data
);

  localparam logic signed [ACC_W-1:0] OUT_MAX =
    {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN =
    {{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

  logic                    w_neg;
  logic                    w_zero;
  logic signed [ACC_W-1:0] w_f;

  assign w_neg  = i_acc[ACC_W-1];
  assign w_zero = (i_acc == '0);

  // NOTE: every signal driven in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    w_f = i_acc;
    unique case (i_mode)
      ACT_RELU:  if (w_neg || w_zero) w_f = '0;
      // >>> on a signed operand rounds toward -inf, as leaky mode requires.
      ACT_LEAKY: if (w_neg) w_f = i_acc >>> LEAKY_SHIFT;
      default:   w_f = i_acc;
    endcase
  end

  always_comb begin
    if (w_f > OUT_MAX)      o_data = OUT_W'(OUT_MAX);
    else if (w_f < OUT_MIN) o_data = OUT_W'(OUT_MIN);
    else                    o_data = OUT_W'(w_f);
  end

endmodule

// File: rtl/mlp_neuron_stream.sv
// Streaming neuron: accumulates LEN signed products x*w onto a per-vector
// bias with a saturating accumulator, then presents the activated, narrowed
// result and holds it until the consumer accepts it.
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand beat handshake
//   in_x, in_w            signed operands (IN_W, W_W)
//   bias, act_mode        sampled on the first beat of each vector
//   out_valid / out_ready result handshake
//   out_data              activated, saturated result (OUT_W)
//   out_acc               raw accumulator value (ACC_W)
//   out_sat               accumulator clipped at least once in this vector
module mlp_neuron_stream
  import mlp_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int W_W   = 4,
  parameter int ACC_W = 16,
  parameter int OUT_W = 8,
  parameter int LEN   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_x,
  input  logic signed [W_W-1:0]   in_w,
  input  logic signed [ACC_W-1:0] bias,
  input  logic        [1:0]       act_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic signed [ACC_W-1:0] out_acc,
  output logic                    out_sat
);

  localparam int PROD_W = IN_W + W_W;
  localparam int CNT_W  = $clog2(LEN + 1);

  state_t                  r_state;
  state_t                  w_state_next;
  logic [CNT_W-1:0]        r_count;
  logic signed [ACC_W-1:0] r_acc;
  logic [1:0]              r_mode;
  logic                    r_sat;

  logic                     w_beat;
  logic                     w_first;
  logic                     w_last;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_base;
  sat_res_t                 w_add;
  logic signed [ACC_W-1:0]  w_sum;
  logic                     w_sat_next;
  logic [1:0]               w_mode;
  logic signed [OUT_W-1:0]  w_act_data;

  assign in_ready  = (r_state != ST_EMIT);
  assign out_valid = (r_state == ST_EMIT);
  assign w_beat    = in_valid && in_ready;
  assign w_first   = (r_state == ST_IDLE);
  assign w_last    = w_first ? (LEN == 1) : (r_count == CNT_W'(LEN - 1));

  // Size casts sign-extend both operands so the product keeps full width.
  assign w_prod = PROD_W'(in_x) * PROD_W'(in_w);

  // The first beat of a vector starts from the bias, later beats from acc.
  assign w_base     = w_first ? bias : r_acc;
  assign w_add      = sat_add(SAT_CALC_W'(w_base), SAT_CALC_W'(w_prod), ACC_W);
  assign w_sum      = w_add.sum[ACC_W-1:0];
  assign w_sat_next = w_add.clip || (!w_first && r_sat);
  assign w_mode     = w_first ? act_mode : r_mode;

  // Fed from the value being written into acc, so the activated result is
  // ready to register in the same edge that enters EMIT.
  mlp_act_unit #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_act (
    .i_acc  (w_sum),
    .i_mode (w_mode),
    .o_data (w_act_data)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE, ST_ACCUM: begin
        if (w_beat) w_state_next = w_last ? ST_EMIT : ST_ACCUM;
      end
      ST_EMIT: begin
        if (out_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_acc    <= '0;
      r_mode   <= ACT_NONE;
      r_sat    <= 1'b0;
      out_data <= '0;
      out_acc  <= '0;
      out_sat  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_beat) begin
        r_acc   <= w_sum;
        r_sat   <= w_sat_next;
        r_count <= w_first ? CNT_W'(1) : r_count + CNT_W'(1);
        if (w_first) r_mode <= act_mode;
        if (w_last) begin
          out_data <= w_act_data;
          out_acc  <= w_sum;
          out_sat  <= w_sat_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_mlp_neuron_stream.sv
// Self-checking bench for mlp_neuron_stream (LEN=4): table vectors, hand
// sequences for backpressure and mid-vector reset, and randomized vectors
// compared against an arithmetic reference model.
module tb_mlp_neuron_stream;

  localparam int IN_W  = 4;
  localparam int W_W   = 4;
  localparam int ACC_W = 16;
  localparam int OUT_W = 8;
  localparam int LEN_T = 4;

  localparam int ACC_MAX = 32767;
  localparam int ACC_MIN = -32768;
  localparam int OUT_MAX = 127;
  localparam int OUT_MIN = -128;

  logic                    clk;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_x;
  logic signed [W_W-1:0]   in_w;
  logic signed [ACC_W-1:0] bias;
  logic [1:0]              act_mode;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic signed [ACC_W-1:0] out_acc;
  logic                    out_sat;

  int n_checks;
  int n_errors;
  int vx[LEN_T];
  int vw[LEN_T];

  mlp_neuron_stream #(
    .IN_W (IN_W), .W_W (W_W), .ACC_W (ACC_W), .OUT_W (OUT_W), .LEN (LEN_T)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_w      (in_w),
    .bias      (bias),
    .act_mode  (act_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_acc   (out_acc),
    .out_sat   (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic from the neuron's rules.
  task automatic model(input int b, input int m, output int e_acc,
                       output int e_data, output bit e_sat);
    int acc;
    int f;
    acc   = b;
    e_sat = 1'b0;
    for (int i = 0; i < LEN_T; i++) begin
      acc = acc + vx[i] * vw[i];
      if (acc > ACC_MAX) begin acc = ACC_MAX; e_sat = 1'b1; end
      if (acc < ACC_MIN) begin acc = ACC_MIN; e_sat = 1'b1; end
    end
    case (m)
      1:       f = (acc > 0) ? acc : 0;
      2:       f = (acc >= 0) ? acc : -((-acc + 7) / 8);  // floor(acc/8)
      default: f = acc;
    endcase
    e_acc  = acc;
    e_data = (f > OUT_MAX) ? OUT_MAX : (f < OUT_MIN) ? OUT_MIN : f;
  endtask

  // One accepted beat: drive at negedge, wait (bounded) for in_ready, then
  // return just after the accepting rising edge.
  task automatic beat(input int b, input int m, input int x, input int w);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_x     = IN_W'(x);
    in_w     = W_W'(w);
    bias     = ACC_W'(b);
    act_mode = 2'(m);
    n = 0;
    while (!in_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (n >= 16) check("beat_ready_timeout", in_ready, 1);
    @(posedge clk);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    in_x     = IN_W'($urandom);
    in_w     = W_W'($urandom);
    @(posedge clk);
  endtask

  // Feeds vx/vw as one vector, checks latency and results, holds out_ready
  // low for rdy_delay cycles (checking stability), then completes the handshake.
  task automatic run_vector(input string tag, input int b, input int m,
                            input int e_acc, input int e_data, input bit e_sat,
                            input int gap_max, input int rdy_delay);
    for (int i = 0; i < LEN_T; i++) begin
      int g;
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      for (int k = 0; k < g; k++) idle_cycle();
      // Bias and mode on later beats are noise the DUT must ignore.
      if (i == 0) beat(b, m, vx[i], vw[i]);
      else        beat(int'($urandom), int'($urandom_range(3, 0)), vx[i], vw[i]);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_latency_valid"}, out_valid, 1);
    check({tag, "_in_ready_low"}, in_ready, 0);
    check({tag, "_acc"}, out_acc, e_acc);
    check({tag, "_data"}, out_data, e_data);
    check({tag, "_sat"}, out_sat, e_sat);
    for (int k = 0; k < rdy_delay; k++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_data"}, out_data, e_data);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 0);
  endtask

  typedef struct {
    string name;
    int    b;
    int    m;
    int    x;
    int    w;
    int    e_acc;
    int    e_data;
    bit    e_sat;
  } tv_t;

  tv_t tbl[8];

  initial begin
    int e_acc, e_data;
    bit e_sat;

    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    in_w      = '0;
    bias      = '0;
    act_mode  = '0;
    out_ready = 1'b0;

    tbl[0] = '{"none",      5,      0,  3, -2,  -19,    -19,  1'b0};
    tbl[1] = '{"relu",      5,      1,  3, -2,  -19,      0,  1'b0};
    tbl[2] = '{"leaky",     5,      2,  3, -2,  -19,     -3,  1'b0};
    tbl[3] = '{"narrow",    0,      0, -8, -8,  256,    127,  1'b0};
    tbl[4] = '{"sat_hi",    32760,  0,  7,  7,  32767,  127,  1'b1};
    tbl[5] = '{"sat_clear", 0,      0,  7,  7,  196,    127,  1'b0};
    tbl[6] = '{"sat_lo",    -32760, 3, -8,  7,  -32768, -128, 1'b1};
    tbl[7] = '{"leaky_neg", -100,   2,  1,  1,  -96,    -12,  1'b0};

    #12;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_acc", out_acc, 0);
    check("rst_sat", out_sat, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    foreach (tbl[t]) begin
      for (int i = 0; i < LEN_T; i++) begin
        vx[i] = tbl[t].x;
        vw[i] = tbl[t].w;
      end
      run_vector(tbl[t].name, tbl[t].b, tbl[t].m, tbl[t].e_acc,
                 tbl[t].e_data, tbl[t].e_sat, 0, 0);
    end

    // Backpressure: result held 5 cycles; a pending first beat is refused
    // on the handshake cycle and accepted the cycle after.
    for (int i = 0; i < LEN_T; i++) beat(5, 0, 3, -2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_x     = IN_W'(1);
      in_w     = W_W'(1);
      bias     = ACC_W'(10);
      act_mode = 2'd0;
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_data", out_data, -19);
      check("bp_acc", out_acc, -19);
      check("bp_sat", out_sat, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_drop_valid", out_valid, 0);
    check("bp_ready_back", in_ready, 1);
    @(posedge clk);
    beat(0, 0, 1, 1);
    beat(0, 0, 1, 1);
    @(negedge clk);
    check("bp_not_early", out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_next_valid", out_valid, 1);
    check("bp_next_acc", out_acc, 14);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;

    // Reset after beat 2 discards the partial vector.
    beat(1000, 0, 7, 7);
    beat(0, 0, 7, 7);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_acc", out_acc, 0);
    check("mid_rst_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < LEN_T; i++) begin vx[i] = 3; vw[i] = -2; end
    run_vector("post_rst", 5, 0, -19, -19, 1'b0, 0, 0);

    // Reset while a result is waiting in EMIT.
    for (int i = 0; i < LEN_T; i++) beat(50, 0, 7, 7);
    @(negedge clk);
    in_valid = 1'b0;
    check("emit_rst_pre", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("emit_rst_valid", out_valid, 0);
    check("emit_rst_sat", out_sat, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized vectors against the reference model.
    for (int v = 0; v < 40; v++) begin
      int b, m;
      case ($urandom_range(2, 0))
        0:       b = int'($urandom_range(400, 0)) - 200;
        1:       b = ACC_MAX - int'($urandom_range(200, 0));
        default: b = ACC_MIN + int'($urandom_range(200, 0));
      endcase
      m = int'($urandom_range(3, 0));
      for (int i = 0; i < LEN_T; i++) begin
        vx[i] = int'($urandom_range(15, 0)) - 8;
        vw[i] = int'($urandom_range(15, 0)) - 8;
      end
      model(b, m, e_acc, e_data, e_sat);
      run_vector($sformatf("rnd%0d", v), b, m, e_acc, e_data, e_sat, 2,
                 int'($urandom_range(3, 0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
